// File: rtl/dmem_if_pkg.sv
// dmem_if_pkg: shared types and constants for the data-memory responder.
package dmem_if_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int WORD_BYTES = 4;
    localparam int BE_W = 4;
    localparam logic ERR_OK = 1'b0;
    localparam logic ERR_ADDR = 1'b1;
endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array: single-port word array with byte-enabled synchronous write and registered read.
module dmem_word_array
    import dmem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 128
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic                           re_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [31:0]                    wdata_i,
    input  logic [BE_W-1:0]                be_i,
    output logic [31:0]                    rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i)
            for (int b = 0; b < BE_W; b++)
                if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        if (re_i) rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder for the CPU data-memory port.
// One request in flight; array access happens on the edge that enters RESP.
module dmem_responder
    import dmem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [31:0]     req_addr_i,
    input  logic [31:0]     req_wdata_i,
    input  logic [BE_W-1:0] req_be_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_rdata_o,
    output logic            rsp_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            live_q, we_q, err_q;
    logic [31:0]     addr_q, wdata_q;
    logic [BE_W-1:0] be_q;
    logic            acc, enter_resp, op_we, op_err;
    logic [31:0]     op_addr, op_wdata, arr_rdata;
    logic [BE_W-1:0] op_be;

    // live_q keeps ready low until the first edge after reset release
    assign req_ready_o = live_q && state_q == IDLE;
    assign acc = req_valid_i && req_ready_o;

    // With zero latency the commit edge is the acceptance edge, so use live inputs in IDLE
    assign op_we    = state_q == IDLE ? req_we_i    : we_q;
    assign op_addr  = state_q == IDLE ? req_addr_i  : addr_q;
    assign op_wdata = state_q == IDLE ? req_wdata_i : wdata_q;
    assign op_be    = state_q == IDLE ? req_be_i    : be_q;
    assign op_err   = op_addr[1:0] != 2'b00 || op_addr[31:2] >= 30'(DEPTH_WORDS);

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (acc) begin
                state_d = LATENCY > 0 ? WAIT : RESP;
                cnt_d = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
            end
            WAIT: if (cnt_q == 4'd0) state_d = RESP; else cnt_d = cnt_q - 4'd1;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = state_d == RESP && state_q != RESP;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q <= '0;
            live_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            be_q <= '0;
            err_q <= ERR_OK;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            live_q <= 1'b1;
            if (acc) begin
                we_q <= req_we_i;
                addr_q <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q <= req_be_i;
            end
            if (enter_resp) err_q <= op_err ? ERR_ADDR : ERR_OK;
        end
    end

    dmem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk_i   (clk_i),
        .we_i    (enter_resp && op_we && !op_err),
        .re_i    (enter_resp && !op_we && !op_err),
        .idx_i   (op_addr[AW+1:2]),
        .wdata_i (op_wdata),
        .be_i    (op_be),
        .rdata_o (arr_rdata)
    );

    assign rsp_valid_o = state_q == RESP;
    assign rsp_err_o   = state_q == RESP && err_q;
    assign rsp_rdata_o = (state_q == RESP && !we_q && !err_q) ? arr_rdata : '0;
endmodule
